// File: rtl/mem_map_pkg.sv
// mem_map_pkg
//   Address map and shared types for the unified memory port responder.
//   Holds the region and FSM state enums, the MMIO register offsets, the
//   default MMIO page base and the address decode helper.
package mem_map_pkg;

  typedef enum logic [1:0] {
    REG_TEXT  = 2'd0,
    REG_DATA  = 2'd1,
    REG_MMIO  = 2'd2,
    REG_FAULT = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [7:0]  MMIO_OFF_LED      = 8'h00;
  localparam logic [7:0]  MMIO_OFF_CNT      = 8'h04;
  localparam logic [7:0]  MMIO_OFF_SW       = 8'h08;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFF00_0000;

  // The MMIO page test must come before the addr[28] test, because the MMIO
  // page itself has addr[28] set.
  function automatic region_t decodeRegion(input logic [31:0] addr,
                                           input logic [31:0] mmioBase);
    region_t r;
    if (addr[1:0] != 2'b00) begin
      r = REG_FAULT;
    end else if (addr[31:8] == mmioBase[31:8]) begin
      r = REG_MMIO;
    end else if (addr[28] == 1'b1) begin
      r = REG_DATA;
    end else if (addr[31:28] == 4'h0) begin
      r = REG_TEXT;
    end else begin
      r = REG_FAULT;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_regs.sv
// mmio_regs
//   Board I/O register page: LED register, free-running cycle counter and
//   switch read-back.
// Ports
//   clockCPU     in   core clock
//   reset        in   asynchronous, active-high
//   iWrEn        in   write strobe, valid only on the capture edge of an MMIO write
//   iOffset      in   byte offset inside the MMIO page
//   iWData       in   write data
//   iSwitches    in   board switches
//   oLeds        out  LED register
//   oRValue      out  read value for iOffset (current register contents)
//   oOffsetOk    out  1 when iOffset names an implemented register
module mmio_regs
  import mem_map_pkg::*;
(
  input  logic        clockCPU,
  input  logic        reset,
  input  logic        iWrEn,
  input  logic [7:0]  iOffset,
  input  logic [31:0] iWData,
  input  logic [9:0]  iSwitches,
  output logic [9:0]  oLeds,
  output logic [31:0] oRValue,
  output logic        oOffsetOk
);

  logic [9:0]  leds_r;
  logic [31:0] cycleCnt_r;

  // LED register: loaded by a write to the LED offset.
  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      leds_r <= 10'd0;
    end else if (iWrEn && (iOffset == MMIO_OFF_LED)) begin
      leds_r <= iWData[9:0];
    end else begin
      leds_r <= leds_r;
    end
  end

  // Cycle counter: a write on this edge takes priority over the increment.
  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      cycleCnt_r <= 32'd0;
    end else if (iWrEn && (iOffset == MMIO_OFF_CNT)) begin
      cycleCnt_r <= iWData;
    end else begin
      cycleCnt_r <= cycleCnt_r + 32'd1;
    end
  end

  // Read mux and offset validity.
  always_comb begin
    oRValue   = 32'd0;
    oOffsetOk = 1'b0;
    case (iOffset)
      MMIO_OFF_LED: begin
        oRValue   = {22'd0, leds_r};
        oOffsetOk = 1'b1;
      end
      MMIO_OFF_CNT: begin
        oRValue   = cycleCnt_r;
        oOffsetOk = 1'b1;
      end
      MMIO_OFF_SW: begin
        oRValue   = {22'd0, iSwitches};
        oOffsetOk = 1'b1;
      end
      default: begin
        oRValue   = 32'd0;
        oOffsetOk = 1'b0;
      end
    endcase
  end

  assign oLeds = leds_r;

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the multicycle core's unified memory port.
//   Takes one word request at a time, decodes text RAM / data RAM / MMIO,
//   drives the ramI/ramD ports with optional wait states and returns a
//   one-cycle response carrying read data or a fault flag.
// Ports
//   clockCPU, reset        core clock, asynchronous active-high reset
//   iReq/iWe/iAddr/iWData  request, sampled only while idle
//   oReady/oRData/oFault   one-cycle response
//   oRamAddr/oRamData      word address and write data to ramI/ramD
//   oWrenI/oWrenD          one-cycle write enables for ramI/ramD
//   iQI/iQD                synchronous-read data from ramI/ramD
//   iSwitches/oLeds        board I/O
module mem_bus_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned RAM_AW      = 10,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic              clockCPU,
  input  logic              reset,
  input  logic              iReq,
  input  logic              iWe,
  input  logic [31:0]       iAddr,
  input  logic [31:0]       iWData,
  output logic              oReady,
  output logic [31:0]       oRData,
  output logic              oFault,
  output logic [RAM_AW-1:0] oRamAddr,
  output logic [31:0]       oRamData,
  output logic              oWrenI,
  output logic              oWrenD,
  input  logic [31:0]       iQI,
  input  logic [31:0]       iQD,
  input  logic [9:0]        iSwitches,
  output logic [9:0]        oLeds
);

  // WAIT holds WAIT_CYCLES cycles, so the counter is loaded with one less.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES != 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_r;
  logic [3:0]        waitCnt_r;
  logic              ready_r;
  logic              fault_r;
  logic [31:0]       rData_r;
  logic              rdRam_r;
  logic              rdFromD_r;
  logic [RAM_AW-1:0] ramAddr_r;
  logic [31:0]       ramData_r;
  logic              wrenI_r;
  logic              wrenD_r;

  region_t           region_s;
  logic              capture_s;
  logic              mmioWrEn_s;
  logic [31:0]       mmioRValue_s;
  logic              mmioOffsetOk_s;
  logic              reqFault_s;

  // The request is decoded on the capture edge itself so that MMIO and fault
  // responses can be ready in the very next cycle.
  assign region_s   = decodeRegion(iAddr, MMIO_BASE);
  assign capture_s  = (state_r == ST_IDLE) && iReq;
  assign mmioWrEn_s = capture_s && iWe && (region_s == REG_MMIO) && mmioOffsetOk_s;
  assign reqFault_s = (region_s == REG_FAULT) ||
                      ((region_s == REG_MMIO) && !mmioOffsetOk_s);

  mmio_regs uMmio (
    .clockCPU  (clockCPU),
    .reset     (reset),
    .iWrEn     (mmioWrEn_s),
    .iOffset   (iAddr[7:0]),
    .iWData    (iWData),
    .iSwitches (iSwitches),
    .oLeds     (oLeds),
    .oRValue   (mmioRValue_s),
    .oOffsetOk (mmioOffsetOk_s)
  );

  // Request FSM with registered handshake, RAM port and response registers.
  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      waitCnt_r <= 4'd0;
      ready_r   <= 1'b0;
      fault_r   <= 1'b0;
      rData_r   <= 32'd0;
      rdRam_r   <= 1'b0;
      rdFromD_r <= 1'b0;
      ramAddr_r <= '0;
      ramData_r <= 32'd0;
      wrenI_r   <= 1'b0;
      wrenD_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iReq) begin
            if ((region_s == REG_TEXT) || (region_s == REG_DATA)) begin
              ramAddr_r <= iAddr[RAM_AW+1:2];
              ramData_r <= iWData;
              wrenI_r   <= iWe && (region_s == REG_TEXT);
              wrenD_r   <= iWe && (region_s == REG_DATA);
              rdRam_r   <= !iWe;
              rdFromD_r <= (region_s == REG_DATA);
              state_r   <= ST_ACCESS;
            end else begin
              ready_r   <= 1'b1;
              fault_r   <= reqFault_s;
              rData_r   <= (reqFault_s || iWe) ? 32'd0 : mmioRValue_s;
              rdRam_r   <= 1'b0;
              state_r   <= ST_RESP;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          wrenI_r <= 1'b0;
          wrenD_r <= 1'b0;
          if (WAIT_CYCLES != 0) begin
            waitCnt_r <= WAIT_LOAD;
            state_r   <= ST_WAIT;
          end else begin
            ready_r <= 1'b1;
            state_r <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (waitCnt_r == 4'd0) begin
            ready_r <= 1'b1;
            state_r <= ST_RESP;
          end else begin
            waitCnt_r <= waitCnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          ready_r <= 1'b0;
          fault_r <= 1'b0;
          rData_r <= 32'd0;
          rdRam_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          fault_r <= 1'b0;
          wrenI_r <= 1'b0;
          wrenD_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM q is only valid one cycle after the address, i.e. during RESP, so RAM
  // read data is passed straight through from the selected RAM.
  assign oRData   = (ready_r && rdRam_r) ? (rdFromD_r ? iQD : iQI) : rData_r;
  assign oReady   = ready_r;
  assign oFault   = fault_r;
  assign oRamAddr = ramAddr_r;
  assign oRamData = ramData_r;
  assign oWrenI   = wrenI_r;
  assign oWrenD   = wrenD_r;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with no wait states and
// one with three wait states. Inputs change and outputs are sampled on the
// falling clock edge; "cycle N" is the cycle after the Nth rising edge
// counted from the request edge (edge 0).
module tb_mem_bus_responder;

  logic        clockCPU = 1'b0;
  logic        reset;
  logic        iReq0, iReq3, iWe;
  logic [31:0] iAddr, iWData, iQI, iQD;
  logic [9:0]  iSwitches;

  logic        oReady0, oFault0, oWrenI0, oWrenD0;
  logic [31:0] oRData0, oRamData0;
  logic [9:0]  oRamAddr0, oLeds0;
  logic        oReady3, oFault3, oWrenI3, oWrenD3;
  logic [31:0] oRData3, oRamData3;
  logic [9:0]  oRamAddr3, oLeds3;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clockCPU = ~clockCPU;

  mem_bus_responder #(.WAIT_CYCLES(0)) dut0 (
    .clockCPU(clockCPU), .reset(reset), .iReq(iReq0), .iWe(iWe),
    .iAddr(iAddr), .iWData(iWData), .oReady(oReady0), .oRData(oRData0),
    .oFault(oFault0), .oRamAddr(oRamAddr0), .oRamData(oRamData0),
    .oWrenI(oWrenI0), .oWrenD(oWrenD0), .iQI(iQI), .iQD(iQD),
    .iSwitches(iSwitches), .oLeds(oLeds0)
  );

  mem_bus_responder #(.WAIT_CYCLES(3)) dut3 (
    .clockCPU(clockCPU), .reset(reset), .iReq(iReq3), .iWe(iWe),
    .iAddr(iAddr), .iWData(iWData), .oReady(oReady3), .oRData(oRData3),
    .oFault(oFault3), .oRamAddr(oRamAddr3), .oRamData(oRamData3),
    .oWrenI(oWrenI3), .oWrenD(oWrenD3), .iQI(iQI), .iQD(iQD),
    .iSwitches(iSwitches), .oLeds(oLeds3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clockCPU);
  endtask

  initial begin
    reset = 1'b1; iReq0 = 1'b0; iReq3 = 1'b0; iWe = 1'b0;
    iAddr = 32'd0; iWData = 32'd0; iQI = 32'd0; iQD = 32'd0; iSwitches = 10'd0;

    // Reset state
    nextCycle();
    chk("rst_ready",  {31'd0, oReady0}, 32'd0);
    chk("rst_fault",  {31'd0, oFault0}, 32'd0);
    chk("rst_rdata",  oRData0, 32'd0);
    chk("rst_wren",   {30'd0, oWrenI0, oWrenD0}, 32'd0);
    chk("rst_leds",   {22'd0, oLeds0}, 32'd0);
    reset = 1'b0;
    nextCycle();

    // 1: text RAM read, no wait states
    iReq0 = 1'b1; iWe = 1'b0; iAddr = 32'h0040_0010; iQI = 32'hDEAD_BEEF;
    nextCycle(); iReq0 = 1'b0;
    chk("t1_c1_ready",   {31'd0, oReady0}, 32'd0);
    chk("t1_c1_ramaddr", {22'd0, oRamAddr0}, 32'd4);
    chk("t1_c1_wren",    {30'd0, oWrenI0, oWrenD0}, 32'd0);
    nextCycle();
    chk("t1_c2_ready", {31'd0, oReady0}, 32'd1);
    chk("t1_c2_rdata", oRData0, 32'hDEAD_BEEF);
    chk("t1_c2_fault", {31'd0, oFault0}, 32'd0);
    nextCycle();
    chk("t1_c3_ready", {31'd0, oReady0}, 32'd0);

    // 2: data RAM write
    iReq0 = 1'b1; iWe = 1'b1; iAddr = 32'h1001_0008; iWData = 32'h1234_5678;
    nextCycle(); iReq0 = 1'b0;
    chk("t2_c1_wrend",   {31'd0, oWrenD0}, 32'd1);
    chk("t2_c1_wreni",   {31'd0, oWrenI0}, 32'd0);
    chk("t2_c1_ramaddr", {22'd0, oRamAddr0}, 32'd2);
    chk("t2_c1_ramdata", oRamData0, 32'h1234_5678);
    nextCycle();
    chk("t2_c2_wrend", {31'd0, oWrenD0}, 32'd0);
    chk("t2_c2_ready", {31'd0, oReady0}, 32'd1);
    chk("t2_c2_rdata", oRData0, 32'd0);
    nextCycle();

    // 4: LED write, switch read, LED read-back
    iReq0 = 1'b1; iWe = 1'b1; iAddr = 32'hFF00_0000; iWData = 32'h0000_03FF;
    nextCycle(); iReq0 = 1'b0;
    chk("t4_led_ready", {31'd0, oReady0}, 32'd1);
    chk("t4_led_fault", {31'd0, oFault0}, 32'd0);
    chk("t4_leds",      {22'd0, oLeds0}, 32'h0000_03FF);
    nextCycle();
    chk("t4_led_c2_ready", {31'd0, oReady0}, 32'd0);
    iReq0 = 1'b1; iWe = 1'b0; iAddr = 32'hFF00_0008; iSwitches = 10'h155;
    nextCycle(); iReq0 = 1'b0;
    chk("t4_sw_ready", {31'd0, oReady0}, 32'd1);
    chk("t4_sw_rdata", oRData0, 32'h0000_0155);
    nextCycle();
    iReq0 = 1'b1; iWe = 1'b1; iAddr = 32'hFF00_0008; iWData = 32'h0000_0000;
    nextCycle(); iReq0 = 1'b0;
    chk("t4_swwr_fault", {31'd0, oFault0}, 32'd0);
    chk("t4_swwr_leds",  {22'd0, oLeds0}, 32'h0000_03FF);
    nextCycle();
    iReq0 = 1'b1; iWe = 1'b0; iAddr = 32'hFF00_0000;
    nextCycle(); iReq0 = 1'b0;
    chk("t4_ledrd_rdata", oRData0, 32'h0000_03FF);
    nextCycle();

    // 5: misaligned and unmapped reads, bad-offset MMIO write
    iReq0 = 1'b1; iWe = 1'b0; iAddr = 32'h0040_0002;
    nextCycle(); iReq0 = 1'b0;
    chk("t5_mis_ready", {31'd0, oReady0}, 32'd1);
    chk("t5_mis_fault", {31'd0, oFault0}, 32'd1);
    chk("t5_mis_rdata", oRData0, 32'd0);
    chk("t5_mis_wren",  {30'd0, oWrenI0, oWrenD0}, 32'd0);
    nextCycle();
    iReq0 = 1'b1; iWe = 1'b0; iAddr = 32'h2000_0000;
    nextCycle(); iReq0 = 1'b0;
    chk("t5_unm_ready", {31'd0, oReady0}, 32'd1);
    chk("t5_unm_fault", {31'd0, oFault0}, 32'd1);
    chk("t5_unm_rdata", oRData0, 32'd0);
    nextCycle();
    chk("t5_unm_wren", {30'd0, oWrenI0, oWrenD0}, 32'd0);
    iReq0 = 1'b1; iWe = 1'b1; iAddr = 32'hFF00_000C; iWData = 32'h0000_0001;
    nextCycle(); iReq0 = 1'b0;
    chk("t5_badoff_fault", {31'd0, oFault0}, 32'd1);
    chk("t5_badoff_leds",  {22'd0, oLeds0}, 32'h0000_03FF);
    nextCycle();

    // 6: counter write then reads two and four edges later (wraps past 0)
    iReq0 = 1'b1; iWe = 1'b1; iAddr = 32'hFF00_0004; iWData = 32'hFFFF_FFFE;
    nextCycle(); iReq0 = 1'b0;
    chk("t6_cntwr_ready", {31'd0, oReady0}, 32'd1);
    iWe = 1'b0;
    nextCycle();
    iReq0 = 1'b1;
    nextCycle(); iReq0 = 1'b0;
    chk("t6_cnt_rd1", oRData0, 32'hFFFF_FFFF);
    nextCycle();
    iReq0 = 1'b1;
    nextCycle(); iReq0 = 1'b0;
    chk("t6_cnt_rd2", oRData0, 32'h0000_0001);
    nextCycle();

    // 3: three wait states, extra request during WAIT ignored
    iReq3 = 1'b1; iWe = 1'b0; iAddr = 32'h1001_0010; iQD = 32'hCAFE_F00D;
    nextCycle(); iReq3 = 1'b0;
    chk("t3_c1_ready",   {31'd0, oReady3}, 32'd0);
    chk("t3_c1_ramaddr", {22'd0, oRamAddr3}, 32'd4);
    chk("t3_c1_wren",    {30'd0, oWrenI3, oWrenD3}, 32'd0);
    nextCycle();
    chk("t3_c2_ready", {31'd0, oReady3}, 32'd0);
    iReq3 = 1'b1; iAddr = 32'h2000_0000;
    nextCycle(); iReq3 = 1'b0;
    chk("t3_c3_ready",   {31'd0, oReady3}, 32'd0);
    chk("t3_c3_ramaddr", {22'd0, oRamAddr3}, 32'd4);
    nextCycle();
    chk("t3_c4_ready", {31'd0, oReady3}, 32'd0);
    nextCycle();
    chk("t3_c5_ready", {31'd0, oReady3}, 32'd1);
    chk("t3_c5_rdata", oRData3, 32'hCAFE_F00D);
    chk("t3_c5_fault", {31'd0, oFault3}, 32'd0);
    nextCycle();
    chk("t3_c6_ready", {31'd0, oReady3}, 32'd0);
    nextCycle();
    chk("t3_c7_ready", {31'd0, oReady3}, 32'd0);

    // 6b: reset while in ACCESS drops the write enable immediately
    iReq0 = 1'b1; iWe = 1'b1; iAddr = 32'h0040_0020; iWData = 32'h0BAD_0BAD;
    nextCycle(); iReq0 = 1'b0;
    chk("t6_acc_wreni", {31'd0, oWrenI0}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_wreni", {31'd0, oWrenI0}, 32'd0);
    chk("t6_rst_ready", {31'd0, oReady0}, 32'd0);
    chk("t6_rst_leds",  {22'd0, oLeds0}, 32'd0);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    iReq0 = 1'b1; iWe = 1'b0; iAddr = 32'h0040_0020; iQI = 32'h5A5A_A5A5;
    nextCycle(); iReq0 = 1'b0;
    chk("t6_post_c1_ready", {31'd0, oReady0}, 32'd0);
    chk("t6_post_ramaddr",  {22'd0, oRamAddr0}, 32'd8);
    nextCycle();
    chk("t6_post_c2_ready", {31'd0, oReady0}, 32'd1);
    chk("t6_post_rdata",    oRData0, 32'h5A5A_A5A5);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
